// File: rtl/uart_frame_sched.sv
// rtl/uart_frame_sched.sv - round-robin 6-byte UART report framer for three measurement channels
module uart_frame_sched #(
    parameter logic [31:0] GAP_CYCLES  = 32'd2400000,
    parameter logic [7:0]  TAG_F_BEGIN = 8'h74,
    parameter logic [7:0]  TAG_F_END   = 8'h78,
    parameter logic [7:0]  TAG_C_BEGIN = 8'h63,
    parameter logic [7:0]  TAG_C_END   = 8'h79,
    parameter logic [7:0]  TAG_D_BEGIN = 8'h64,
    parameter logic [7:0]  TAG_D_END   = 8'h75
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [2:0]  chan_en,
    input  logic [31:0] pinlv,
    input  logic [31:0] cycle,
    input  logic [31:0] duty_cycle,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  cur_chan,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, SELECT, SEND, GAP} state_t;

    state_t      state_q;
    logic [2:0]  byte_idx_q;
    logic [31:0] gap_cnt_q;
    logic [31:0] shadow_val_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic [1:0]  cur_chan_q;
    logic        frame_done_q;

    logic [1:0]  next_chan_d;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic [31:0] sel_val_d;
    logic [2:0]  nxt_idx;
    logic [7:0]  nxt_byte_d;

    function automatic logic [1:0] succ(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    function automatic logic [7:0] begin_tag(input logic [1:0] c);
        case (c)
            2'd0:    return TAG_F_BEGIN;
            2'd1:    return TAG_C_BEGIN;
            default: return TAG_D_BEGIN;
        endcase
    endfunction

    function automatic logic [7:0] end_tag(input logic [1:0] c);
        case (c)
            2'd0:    return TAG_F_END;
            2'd1:    return TAG_C_END;
            default: return TAG_D_END;
        endcase
    endfunction

    // Round-robin pick: first enabled channel after the last served one, falling back to itself
    always_comb begin
        cand1 = succ(cur_chan_q);
        cand2 = succ(cand1);
        if (chan_en[cand1])
            next_chan_d = cand1;
        else if (chan_en[cand2])
            next_chan_d = cand2;
        else
            next_chan_d = cur_chan_q;
        case (next_chan_d)
            2'd0:    sel_val_d = pinlv;
            2'd1:    sel_val_d = cycle;
            default: sel_val_d = duty_cycle;
        endcase
    end

    // Byte to present after the current one is accepted, taken from the frozen snapshot
    always_comb begin
        nxt_idx = byte_idx_q + 3'd1;
        case (nxt_idx)
            3'd1:    nxt_byte_d = shadow_val_q[31:24];
            3'd2:    nxt_byte_d = shadow_val_q[23:16];
            3'd3:    nxt_byte_d = shadow_val_q[15:8];
            3'd4:    nxt_byte_d = shadow_val_q[7:0];
            default: nxt_byte_d = end_tag(cur_chan_q);
        endcase
    end

    // Frame scheduler FSM with registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= 3'd0;
            gap_cnt_q    <= 32'd0;
            shadow_val_q <= 32'd0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            cur_chan_q   <= 2'd2;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_valid_q <= 1'b0;
                    if (run && (chan_en != 3'b000))
                        state_q <= SELECT;
                end
                SELECT: begin
                    if (chan_en == 3'b000) begin
                        state_q <= IDLE;
                    end else begin
                        cur_chan_q   <= next_chan_d;
                        shadow_val_q <= sel_val_d;
                        byte_idx_q   <= 3'd0;
                        tx_data_q    <= begin_tag(next_chan_d);
                        tx_valid_q   <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_valid_q && tx_ready) begin
                        if (byte_idx_q == 3'd5) begin
                            tx_valid_q   <= 1'b0;
                            frame_done_q <= 1'b1;
                            gap_cnt_q    <= 32'd0;
                            state_q      <= (GAP_CYCLES == 32'd0) ? IDLE : GAP;
                        end else begin
                            byte_idx_q <= nxt_idx;
                            tx_data_q  <= nxt_byte_d;
                        end
                    end
                end
                GAP: begin
                    tx_valid_q <= 1'b0;
                    if (gap_cnt_q == GAP_CYCLES - 32'd1)
                        state_q <= IDLE;
                    else
                        gap_cnt_q <= gap_cnt_q + 32'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign cur_chan   = cur_chan_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// tb/tb_uart_frame_sched.sv - directed self-checking bench for uart_frame_sched
module tb_uart_frame_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [2:0]  chan_en = 3'b000;
    logic [31:0] pinlv = 32'd0;
    logic [31:0] cycle = 32'd0;
    logic [31:0] duty_cycle = 32'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [1:0]  cur_chan;
    logic        busy;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    uart_frame_sched #(.GAP_CYCLES(32'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .chan_en    (chan_en),
        .pinlv      (pinlv),
        .cycle      (cycle),
        .duty_cycle (duty_cycle),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .cur_chan   (cur_chan),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Gathers six accepted bytes; ends at the negedge following the last transfer edge
    task automatic collect_frame(output logic [47:0] f, output int cycles, output bit ok);
        int k = 0;
        f = 48'd0;
        cycles = 0;
        while (k < 6 && cycles < 300) begin
            if (tx_valid && tx_ready) begin
                f = {f[39:0], tx_data};
                k++;
            end
            @(negedge clk);
            cycles++;
        end
        ok = (k == 6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_chk++; if (cur_chan !== 2'd2) begin n_fail++; $display("FAIL reset_cur_chan got %0d want 2", cur_chan); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        do_reset();
        chan_en = 3'b001; run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL idle_run0 got %0d active cycles want 0", bad); end
        bad = 0;
        chan_en = 3'b000; run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL idle_en0 got %0d active cycles want 0", bad); end
        run = 1'b0;
    endtask

    task automatic test_basic();
        logic [47:0] f;
        int cyc;
        int low;
        int fd;
        bit ok;
        do_reset();
        chan_en = 3'b001; pinlv = 32'h12345678; tx_ready = 1'b1;
        run = 1'b1;
        @(negedge clk);
        n_chk++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_select got valid=%b busy=%b want 0/1", tx_valid, busy); end
        @(negedge clk);
        n_chk++; if (tx_valid !== 1'b1 || tx_data !== 8'h74) begin n_fail++; $display("FAIL basic_latency got valid=%b data=%h want 1/74", tx_valid, tx_data); end
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h74_12345678_78) begin n_fail++; $display("FAIL basic_frame got %h want 74123456787 8", f); end
        n_chk++; if (cyc !== 6) begin n_fail++; $display("FAIL basic_b2b got %0d cycles want 6", cyc); end
        n_chk++; if (cur_chan !== 2'd0) begin n_fail++; $display("FAIL basic_cur_chan got %0d want 0", cur_chan); end
        low = 0; fd = 0;
        while (!tx_valid && low < 50) begin
            if (frame_done) fd++;
            low++;
            @(negedge clk);
        end
        n_chk++; if (fd !== 1) begin n_fail++; $display("FAIL basic_frame_done got %0d pulses want 1", fd); end
        n_chk++; if (low !== 6) begin n_fail++; $display("FAIL basic_gap got %0d idle cycles want 6", low); end
        n_chk++; if (tx_data !== 8'h74) begin n_fail++; $display("FAIL basic_next_tag got %h want 74", tx_data); end
        run = 1'b0;
    endtask

    task automatic test_rotation();
        logic [47:0] f;
        int cyc;
        bit ok;
        do_reset();
        chan_en = 3'b101; pinlv = 32'h12345678; cycle = 32'hAAAA0000; duty_cycle = 32'h00000032;
        run = 1'b1;
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h74_12345678_78) begin n_fail++; $display("FAIL rot_frame1 got %h want 741234567878", f); end
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h64_00000032_75) begin n_fail++; $display("FAIL rot_frame2 got %h want 640000003275", f); end
        n_chk++; if (cur_chan !== 2'd2) begin n_fail++; $display("FAIL rot_cur_chan got %0d want 2", cur_chan); end
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h74_12345678_78) begin n_fail++; $display("FAIL rot_frame3 got %h want 741234567878", f); end
        chan_en = 3'b111;
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h63_AAAA0000_79) begin n_fail++; $display("FAIL rot_period got %h want 63aaaa000079", f); end
        n_chk++; if (cur_chan !== 2'd1) begin n_fail++; $display("FAIL rot_cur_chan_p got %0d want 1", cur_chan); end
        run = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic [95:0] got;
        logic [7:0]  prev_data;
        bit prev_stall;
        int xfers;
        int stall_err;
        int stalls;
        pat = 16'b1011_0100_1101_1001;
        do_reset();
        chan_en = 3'b001; pinlv = 32'hCAFEF00D;
        run = 1'b1;
        xfers = 0; stall_err = 0; stalls = 0; prev_stall = 1'b0; prev_data = 8'h00; got = 96'd0;
        for (int i = 0; i < 600 && xfers < 12; i++) begin
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_err++;
            tx_ready = pat[i[3:0]];
            if (tx_valid && tx_ready) begin
                got = {got[87:0], tx_data};
                xfers++;
            end
            prev_stall = tx_valid && !tx_ready;
            if (prev_stall) stalls++;
            prev_data = tx_data;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        n_chk++; if (xfers !== 12) begin n_fail++; $display("FAIL bp_xfers got %0d want 12", xfers); end
        n_chk++; if (got !== 96'h74_CAFEF00D_78_74_CAFEF00D_78) begin n_fail++; $display("FAIL bp_bytes got %h want 74cafef00d7874cafef00d78", got); end
        n_chk++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err); end
        n_chk++; if (stalls == 0) begin n_fail++; $display("FAIL bp_stalls_seen got 0 want >0"); end
        run = 1'b0;
    endtask

    task automatic test_snapshot();
        logic [47:0] f;
        int cyc;
        int k;
        bit ok;
        do_reset();
        chan_en = 3'b001; pinlv = 32'h00000001;
        run = 1'b1;
        k = 0; cyc = 0; f = 48'd0;
        while (k < 6 && cyc < 300) begin
            if (tx_valid && tx_ready) begin
                f = {f[39:0], tx_data};
                k++;
                if (k == 3) pinlv = 32'hFFFFFFFF;
            end
            @(negedge clk);
            cyc++;
        end
        n_chk++; if (k !== 6 || f !== 48'h74_00000001_78) begin n_fail++; $display("FAIL snap_first got %h want 740000000178", f); end
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h74_FFFFFFFF_78) begin n_fail++; $display("FAIL snap_second got %h want 74ffffffff78", f); end
        run = 1'b0;
    endtask

    task automatic test_run_clear();
        logic [47:0] f;
        int cyc;
        int w;
        int vcnt;
        bit ok;
        do_reset();
        chan_en = 3'b001; pinlv = 32'h00000005;
        run = 1'b1;
        w = 0;
        while (!tx_valid && w < 20) begin @(negedge clk); w++; end
        run = 1'b0;
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h74_00000005_78) begin n_fail++; $display("FAIL runclr_frame got %h want 740000000578", f); end
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid) vcnt++;
        end
        n_chk++; if (vcnt !== 0) begin n_fail++; $display("FAIL runclr_quiet got %0d valid cycles want 0", vcnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL runclr_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] f;
        int cyc;
        int k;
        bit ok;
        do_reset();
        chan_en = 3'b011; pinlv = 32'h0BADF00D; cycle = 32'h11223344;
        run = 1'b1;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 100) begin
            if (tx_valid && tx_ready) k++;
            @(negedge clk);
            cyc++;
        end
        n_chk++; if (tx_valid !== 1'b1 || tx_data !== 8'hF0) begin n_fail++; $display("FAIL rstmid_pre got valid=%b data=%h want 1/f0", tx_valid, tx_data); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || cur_chan !== 2'd2 || busy !== 1'b0 || frame_done !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_outputs got valid=%b data=%h chan=%0d busy=%b fd=%b want 0/00/2/0/0", tx_valid, tx_data, cur_chan, busy, frame_done); end
        rst = 1'b0;
        collect_frame(f, cyc, ok);
        n_chk++; if (!ok || f !== 48'h74_0BADF00D_78) begin n_fail++; $display("FAIL rstmid_restart got %h want 740badf00d78", f); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_rotation();
        test_backpressure();
        test_snapshot();
        test_run_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
